// File: rtl/openhmc_counter_bank.sv
// openhmc_counter_bank: independent accumulating counters with sticky overflow flags and a registered read port.
// Define OPENHMC_COUNTER_SATURATE_EN to saturate at all-ones on overflow instead of wrapping.
module openhmc_counter_bank #(
  parameter  int DATASIZE = 16,
  parameter  int CHANNELS = 4,
  parameter  int INCWIDTH = 4,
  localparam int SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         res_n,
  input  logic [CHANNELS*INCWIDTH-1:0] increment,
  input  logic [CHANNELS-1:0]          load_enable,
  input  logic                         rd_en,
  input  logic [SELW-1:0]              rd_sel,
  output logic [CHANNELS*DATASIZE-1:0] value,
  output logic [CHANNELS-1:0]          overflow,
  output logic [DATASIZE-1:0]          rd_data,
  output logic                         rd_valid
);

  logic [DATASIZE-1:0] rd_mux;
  logic [DATASIZE-1:0] rd_data_q;
  logic                rd_valid_q;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    logic [INCWIDTH-1:0] inc;
    logic [DATASIZE:0]   sum;
    logic [DATASIZE-1:0] cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                clr_q;

    assign inc = increment[gi*INCWIDTH +: INCWIDTH];
    // One extra bit so the carry out is the overflow event.
    assign sum = {1'b0, cnt_q} + (DATASIZE+1)'(inc);

    always_comb begin
      cnt_d = sum[DATASIZE-1:0];
      ovf_d = ovf_q;
      if (clr_q) begin
        cnt_d = DATASIZE'(inc);
        ovf_d = 1'b0;
      end else if (sum[DATASIZE]) begin
`ifdef OPENHMC_COUNTER_SATURATE_EN
        cnt_d = '1;
`else
        cnt_d = sum[DATASIZE-1:0];
`endif
        ovf_d = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
        clr_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
        clr_q <= load_enable[gi];
      end
    end

    assign value[gi*DATASIZE +: DATASIZE] = cnt_q;
    assign overflow[gi]                   = ovf_q;
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (rd_sel == SELW'(i)) rd_mux = value[i*DATASIZE +: DATASIZE];
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= rd_mux;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_openhmc_counter_bank.sv
// Testbench for openhmc_counter_bank: random and directed stimulus against a behavioural model, read data via scoreboard queue.
module tb_openhmc_counter_bank;
  localparam int DS = 16;
  localparam int CH = 3;
  localparam int IW = 16;

  logic            clk = 1'b0;
  logic            res_n;
  logic [CH*IW-1:0] increment;
  logic [CH-1:0]   load_enable;
  logic            rd_en;
  logic [1:0]      rd_sel;
  logic [CH*DS-1:0] value;
  logic [CH-1:0]   overflow;
  logic [DS-1:0]   rd_data;
  logic            rd_valid;

  openhmc_counter_bank #(.DATASIZE(DS), .CHANNELS(CH), .INCWIDTH(IW)) dut (
    .clk(clk), .res_n(res_n), .increment(increment), .load_enable(load_enable),
    .rd_en(rd_en), .rd_sel(rd_sel), .value(value), .overflow(overflow),
    .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: counters as plain integers
  int m_cnt  [CH];
  bit m_ovf  [CH];
  bit m_pend [CH];
  int exp_q [$];
  int last_rd = 0;

`ifdef OPENHMC_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_cnt[c] = 0; m_ovf[c] = 0; m_pend[c] = 0;
    end
  endtask

  task automatic check_state(input string tag);
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("%s value[%0d]", tag, c), 32'(value[c*DS +: DS]), m_cnt[c]);
      chk($sformatf("%s overflow[%0d]", tag, c), 32'(overflow[c]), 32'(m_ovf[c]));
    end
  endtask

  // Called at a negedge: drive inputs, advance the model, check after the edge, return at next negedge.
  task automatic step(input logic [15:0] i0, input logic [15:0] i1, input logic [15:0] i2,
                      input logic [2:0] le, input logic re, input logic [1:0] sel);
    int incs [CH];
    int s;
    incs[0] = i0; incs[1] = i1; incs[2] = i2;
    increment   = {i2, i1, i0};
    load_enable = le;
    rd_en       = re;
    rd_sel      = sel;
    if (re) begin
      if (sel < CH) exp_q.push_back(m_cnt[sel]);
      else          exp_q.push_back(0);
    end
    for (int c = 0; c < CH; c++) begin
      if (m_pend[c]) begin
        m_cnt[c] = incs[c];
        m_ovf[c] = 0;
      end else begin
        s = m_cnt[c] + incs[c];
        if (s > 65535) begin
          m_ovf[c] = 1;
          m_cnt[c] = SAT ? 65535 : s - 65536;
        end else begin
          m_cnt[c] = s;
        end
      end
      m_pend[c] = le[c];
    end
    @(posedge clk);
    #1;
    check_state("step");
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(16'd0, 16'd0, 16'd0, 3'b000, 1'b0, 2'd0);
  endtask

  function automatic logic [15:0] rand_inc();
    case ($urandom_range(0, 4))
      0, 1:    return 16'd0;
      2:       return 16'($urandom_range(1, 15));
      3:       return 16'($urandom);
      default: return 16'($urandom_range(16'hF000, 16'hFFFF));
    endcase
  endfunction

  // Monitor: pops an expectation whenever the DUT presents read data.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (!res_n) begin
        last_rd = 0;
      end else if (rd_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rd_valid: got 1 with no read outstanding at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", 32'(rd_data), e);
          last_rd = e;
        end
      end else begin
        chk("rd_data_hold", 32'(rd_data), last_rd);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    res_n = 1'b0; increment = '0; load_enable = '0; rd_en = 1'b0; rd_sel = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_state("reset");
    chk("reset rd_valid", 32'(rd_valid), 0);
    chk("reset rd_data", 32'(rd_data), 0);
    #2 res_n = 1'b1;
    @(negedge clk);

    // ch0 +3 four times, then read
    repeat (4) step(16'd3, 16'd0, 16'd0, 3'b000, 1'b0, 2'd0);
    step(16'd0, 16'd0, 16'd0, 3'b000, 1'b1, 2'd0);
    idle(1);

    // ch1 to 0xFFFE via clear-with-increment, then +5
    step(16'd0, 16'd0, 16'd0, 3'b010, 1'b0, 2'd0);
    step(16'd0, 16'hFFFE, 16'd0, 3'b000, 1'b0, 2'd0);
    step(16'd0, 16'd5, 16'd0, 3'b000, 1'b0, 2'd0);
    step(16'd0, 16'd0, 16'd0, 3'b000, 1'b1, 2'd1);

    // ch2 overflow, then one-cycle-latency clear
    step(16'd0, 16'd0, 16'hFFFF, 3'b000, 1'b0, 2'd0);
    step(16'd0, 16'd0, 16'd1, 3'b000, 1'b0, 2'd0);
    step(16'd0, 16'd0, 16'd0, 3'b100, 1'b0, 2'd0);
    step(16'd0, 16'd0, 16'd0, 3'b000, 1'b0, 2'd0);

    // ch0 overflow, then clear with inc=7
    step(16'hFFFF, 16'd0, 16'd0, 3'b000, 1'b0, 2'd0);
    step(16'd0, 16'd0, 16'd0, 3'b001, 1'b0, 2'd0);
    step(16'd7, 16'd0, 16'd0, 3'b000, 1'b0, 2'd0);

    // out-of-range select, then back-to-back reads
    step(16'd0, 16'd0, 16'd0, 3'b000, 1'b1, 2'd3);
    for (int k = 0; k < 8; k++) step(16'd1, 16'd2, 16'd3, 3'b000, 1'b1, 2'(k % 4));
    idle(1);

    for (int k = 0; k < 400; k++) begin
      step(rand_inc(), rand_inc(), rand_inc(),
           3'($urandom_range(0, 7) == 0 ? $urandom_range(1, 7) : 0),
           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end

    // Mid-operation asynchronous reset with nonzero counters
    step(16'd100, 16'd200, 16'd300, 3'b000, 1'b1, 2'd2);
    step(16'd0, 16'd0, 16'd0, 3'b111, 1'b1, 2'd1);
    increment = '0; load_enable = '0; rd_en = 1'b0;
    #2 res_n = 1'b0;
    #1;
    model_reset();
    exp_q.delete();
    check_state("async_reset");
    chk("async_reset rd_valid", 32'(rd_valid), 0);
    chk("async_reset rd_data", 32'(rd_data), 0);
    @(posedge clk);
    @(negedge clk);
    #2 res_n = 1'b1;
    @(negedge clk);
    repeat (3) step(16'd4, 16'd5, 16'd6, 3'b000, 1'b0, 2'd0);
    step(16'd0, 16'd0, 16'd0, 3'b000, 1'b1, 2'd2);
    idle(3);

    chk("rd_pending", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
